// File: rtl/multi_tc.sv
// ----------------------------------------------------------------------------
// multi_tc : memory-mapped multi-channel timer/counter.
//
// Provides N_CH independent down-counters. Each channel has its own
// prescaler, one-shot/periodic mode, sticky pending flag and interrupt mask.
// The OR of all unmasked pending flags drives the single IRQ line.
//
// Register map, per channel ch at byte offset ch*16:
//   +0 CTRL   [0] EN  [1] MODE (0 one-shot, 1 periodic)  [3] IM
//             [8 +: PRESC_W] PRESC
//   +4 PRESET WIDTH bits, read/write
//   +8 COUNT  read-only
//   +C STATUS [0] PEND, write 1 to clear
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-low
//   address  in   [31:2] word address; [3:2] register, [5:4] channel
//   WE       in   write strobe, one cycle per store
//   dataIn   in   [31:0] write data
//   dataOut  out  [31:0] read data, combinational from address
//   irq_vec  out  [N_CH-1:0] per-channel PEND & IM
//   IRQ      out  OR of irq_vec
// ----------------------------------------------------------------------------
module multi_tc #(
    parameter int N_CH    = 2,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     address,
    input  logic            WE,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    output logic [N_CH-1:0] irq_vec,
    output logic            IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Per-channel state
    state_t             r_state  [N_CH];
    logic [PRESC_W-1:0] r_presc  [N_CH];
    logic [PRESC_W-1:0] r_pcnt   [N_CH];
    logic [WIDTH-1:0]   r_preset [N_CH];
    logic [WIDTH-1:0]   r_count  [N_CH];
    logic [N_CH-1:0]    r_en;
    logic [N_CH-1:0]    r_mode;
    logic [N_CH-1:0]    r_im;
    logic [N_CH-1:0]    r_pend;

    // Bus decode
    logic [1:0]      w_reg_sel;
    logic [1:0]      w_ch_sel;
    logic [N_CH-1:0] w_wr_hit;
    logic            w_unused_bits;

    assign w_reg_sel = address[3:2];
    assign w_ch_sel  = address[5:4];

    // The bridge decodes the upper address bits; they carry no meaning here.
    assign w_unused_bits = &{1'b0, address[31:6], dataIn};

    // NOTE: every signal assigned in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        w_wr_hit = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            w_wr_hit[ch] = WE && (w_ch_sel == 2'(ch));
        end
    end

    // A bus write to a channel freezes that channel's FSM and prescaler for
    // the cycle, so a write can never race an expiry on PEND or COUNT.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r_state[ch]  <= ST_IDLE;
                r_presc[ch]  <= '0;
                r_pcnt[ch]   <= '0;
                r_preset[ch] <= '0;
                r_count[ch]  <= '0;
            end
            r_en   <= '0;
            r_mode <= '0;
            r_im   <= '0;
            r_pend <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (w_wr_hit[ch]) begin
                    case (w_reg_sel)
                        REG_CTRL: begin
                            r_en[ch]    <= dataIn[0];
                            r_mode[ch]  <= dataIn[1];
                            r_im[ch]    <= dataIn[3];
                            r_presc[ch] <= dataIn[8 +: PRESC_W];
                        end
                        REG_PRESET: r_preset[ch] <= dataIn[WIDTH-1:0];
                        REG_STATUS: begin
                            if (dataIn[0]) begin
                                r_pend[ch] <= 1'b0;
                            end
                        end
                        default: ; // COUNT is read-only
                    endcase
                end else begin
                    case (r_state[ch])
                        ST_IDLE: begin
                            if (r_en[ch]) begin
                                r_state[ch] <= ST_LOAD;
                            end
                        end
                        ST_LOAD: begin
                            r_count[ch] <= r_preset[ch];
                            r_pcnt[ch]  <= '0;
                            r_state[ch] <= ST_COUNT;
                        end
                        ST_COUNT: begin
                            if (!r_en[ch]) begin
                                r_state[ch] <= ST_IDLE;
                            end else if (r_pcnt[ch] == r_presc[ch]) begin
                                r_pcnt[ch] <= '0;
                                // PRESET of 0 or 1 both expire on the first tick.
                                if (r_count[ch] > WIDTH'(1)) begin
                                    r_count[ch] <= r_count[ch] - WIDTH'(1);
                                end else begin
                                    r_count[ch] <= '0;
                                    r_pend[ch]  <= 1'b1;
                                    r_state[ch] <= ST_EXPIRE;
                                end
                            end else begin
                                r_pcnt[ch] <= r_pcnt[ch] + PRESC_W'(1);
                            end
                        end
                        ST_EXPIRE: begin
                            if (r_mode[ch]) begin
                                r_state[ch] <= ST_LOAD;
                            end else begin
                                r_en[ch]    <= 1'b0;
                                r_state[ch] <= ST_IDLE;
                            end
                        end
                        default: r_state[ch] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Read mux; unimplemented channels and bits read as zero.
    always_comb begin
        dataOut = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (w_ch_sel == 2'(ch)) begin
                case (w_reg_sel)
                    REG_CTRL: begin
                        dataOut[0]             = r_en[ch];
                        dataOut[1]             = r_mode[ch];
                        dataOut[3]             = r_im[ch];
                        dataOut[8 +: PRESC_W]  = r_presc[ch];
                    end
                    REG_PRESET: dataOut = 32'(r_preset[ch]);
                    REG_COUNT:  dataOut = 32'(r_count[ch]);
                    default:    dataOut[0] = r_pend[ch];
                endcase
            end
        end
    end

    assign irq_vec = r_pend & r_im;
    assign IRQ     = |irq_vec;

endmodule

// File: tb/tb_multi_tc.sv
// ----------------------------------------------------------------------------
// tb_multi_tc : self-checking bench for multi_tc (N_CH=2, WIDTH=32, PRESC_W=8).
// A register-access vector table covers reset values, field masking and
// out-of-range channels; hand-written sequences cover the timing corners.
// ----------------------------------------------------------------------------
module tb_multi_tc;

    logic        clk;
    logic        reset;
    logic [31:2] address;
    logic        WE;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [1:0]  irq_vec;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    multi_tc #(.N_CH(2), .WIDTH(32), .PRESC_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .WE      (WE),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .irq_vec (irq_vec),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus write; consumes exactly one rising edge, returns 1 ns after it.
    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        address = {24'd0, off[7:2]};
        dataIn  = data;
        WE      = 1'b1;
        @(posedge clk);
        #1;
        WE      = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        address = {24'd0, off[7:2]};
        WE      = 1'b0;
        #1;
        d = dataOut;
    endtask

    task automatic chk_reg(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        check(name, d, exp);
    endtask

    task automatic chk_irq(input string name, input logic [1:0] exp_vec);
        check({name, ".irq_vec"}, 32'(irq_vec), 32'(exp_vec));
        check({name, ".IRQ"}, 32'(IRQ), 32'(|exp_vec));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        WE    = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Byte offsets
    localparam logic [7:0] C0_CTRL = 8'h00, C0_PRE = 8'h04, C0_CNT = 8'h08, C0_STS = 8'h0C;
    localparam logic [7:0] C1_CTRL = 8'h10, C1_PRE = 8'h14, C1_CNT = 8'h18, C1_STS = 8'h1C;

    initial begin
        reset   = 1'b0;
        WE      = 1'b0;
        address = '0;
        dataIn  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // ---------------- register access table ----------------
        vecs.push_back('{"rst ch0 ctrl",     1'b0, 8'h00, 32'h0,        32'h0});
        vecs.push_back('{"rst ch0 preset",   1'b0, 8'h04, 32'h0,        32'h0});
        vecs.push_back('{"rst ch1 status",   1'b0, 8'h1C, 32'h0,        32'h0});
        vecs.push_back('{"ctrl field mask",  1'b1, 8'h00, 32'hFFFF_FFF6, 32'h0000_FF02});
        vecs.push_back('{"preset rw",        1'b1, 8'h04, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{"count read-only",  1'b1, 8'h08, 32'h0000_1234, 32'h0});
        vecs.push_back('{"status w1 idle",   1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"ch2 preset wr",    1'b1, 8'h24, 32'h0000_0055, 32'h0});
        vecs.push_back('{"ch0 preset kept",  1'b0, 8'h04, 32'h0,        32'hDEAD_BEEF});
        vecs.push_back('{"ch1 ctrl rw",      1'b1, 8'h10, 32'h0000_0A08, 32'h0000_0A08});
        vecs.push_back('{"ch3 ctrl wr",      1'b1, 8'h30, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"ch0 ctrl kept",    1'b0, 8'h00, 32'h0,        32'h0000_FF02});
        vecs.push_back('{"ch2 status rd",    1'b0, 8'h2C, 32'h0,        32'h0});
        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].off, vecs[i].wdata);
            chk_reg(vecs[i].name, vecs[i].off, vecs[i].exp);
            check({vecs[i].name, ".IRQ"}, 32'(IRQ), 32'd0);
        end

        // ---------------- 1: one-shot, PRESET=5, PRESC=0 ----------------
        do_reset();
        wr(C0_PRE, 32'd5);
        wr(C0_CTRL, 32'h9);                 // edge E0
        step(4);  chk_reg("t1 count@E4", C0_CNT, 32'd3);
        step(2);  chk_reg("t1 count@E6", C0_CNT, 32'd1);
        chk_irq("t1 @E6", 2'b00);
        step(1);  chk_irq("t1 @E7", 2'b01);
        chk_reg("t1 count@E7", C0_CNT, 32'd0);
        chk_reg("t1 status@E7", C0_STS, 32'd1);
        step(1);  chk_reg("t1 ctrl EN cleared", C0_CTRL, 32'h8);
        step(5);  chk_irq("t1 sticky", 2'b01);
        wr(C0_STS, 32'h1);
        chk_irq("t1 cleared", 2'b00);

        // ---------------- 2: periodic, PRESET=3, PRESC=3 ----------------
        do_reset();
        wr(C1_PRE, 32'd3);
        wr(C1_CTRL, 32'h30B);               // edge E0
        step(13); chk_irq("t2 @E13", 2'b00);
        step(1);  chk_irq("t2 first expiry @E14", 2'b10);
        step(13); chk_reg("t2 count@E27", C1_CNT, 32'd1);
        step(1);  chk_reg("t2 count@E28 re-expiry", C1_CNT, 32'd0);
        step(2);  chk_reg("t2 count@E30 reload", C1_CNT, 32'd3);
        chk_irq("t2 pend held", 2'b10);
        wr(C1_STS, 32'h1);                  // edge E31, stalls ch1 once
        chk_irq("t2 cleared", 2'b00);
        step(11); chk_irq("t2 @E42", 2'b00);
        step(1);  chk_irq("t2 re-rise @E43", 2'b10);

        // ---------------- 3: disable mid-count, re-enable ----------------
        do_reset();
        wr(C0_PRE, 32'd6);
        wr(C0_CTRL, 32'h9);
        step(6);  chk_reg("t3 count before stop", C0_CNT, 32'd2);
        wr(C0_CTRL, 32'h8);
        step(10); chk_reg("t3 count frozen", C0_CNT, 32'd2);
        chk_reg("t3 no pend", C0_STS, 32'd0);
        chk_irq("t3 no irq", 2'b00);
        wr(C0_CTRL, 32'h9);                 // edge F0
        step(2);  chk_reg("t3 reload", C0_CNT, 32'd6);
        step(5);  chk_irq("t3 @F7", 2'b00);
        step(1);  chk_irq("t3 @F8", 2'b01);

        // ---------------- 4: two channels, write stalls only ch1 ----------------
        do_reset();
        wr(C0_PRE, 32'd4);
        wr(C1_PRE, 32'd4);
        wr(C0_CTRL, 32'h9);                 // edge A
        wr(C1_CTRL, 32'h9);                 // edge A+1
        step(2);
        wr(C1_PRE, 32'd100);                // edge A+4
        chk_irq("t4 @A4", 2'b00);
        step(1);  chk_irq("t4 @A5", 2'b00);
        step(1);  chk_irq("t4 ch0 @A6", 2'b01);
        step(1);  chk_irq("t4 ch1 late @A7", 2'b01);
        chk_reg("t4 ch1 count@A7", C1_CNT, 32'd1);
        step(1);  chk_irq("t4 both @A8", 2'b11);
        chk_reg("t4 ch1 new preset", C1_PRE, 32'd100);
        wr(C0_STS, 32'h1);
        chk_irq("t4 ch1 only", 2'b10);
        wr(C1_STS, 32'h1);
        chk_irq("t4 none", 2'b00);

        // ---------------- 5: masked expiry, unmask later ----------------
        do_reset();
        wr(C0_PRE, 32'd2);
        wr(C0_CTRL, 32'h1);
        step(6);  chk_reg("t5 pend masked", C0_STS, 32'd1);
        chk_irq("t5 masked", 2'b00);
        chk_reg("t5 en cleared", C0_CTRL, 32'h0);
        wr(C0_CTRL, 32'h8);
        chk_irq("t5 unmasked", 2'b01);

        // ---------------- 6: reset mid-count ----------------
        do_reset();
        wr(C0_PRE, 32'd50);
        wr(C0_CTRL, 32'h9);                 // edge C
        wr(C1_PRE, 32'd2);
        wr(C1_CTRL, 32'hB);                 // edge C+2
        step(10);
        chk_irq("t6 pre-reset", 2'b10);
        chk_reg("t6 ch0 count@C12", C0_CNT, 32'd40);
        address = {24'd0, C0_PRE[7:2]};
        dataIn  = 32'h77;
        WE      = 1'b1;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        WE    = 1'b0;
        chk_irq("t6 post-reset", 2'b00);
        for (int r = 0; r < 4; r++) begin
            chk_reg($sformatf("t6 ch0 reg%0d", r), 8'(r * 4), 32'd0);
        end
        step(1);
        for (int r = 0; r < 4; r++) begin
            chk_reg($sformatf("t6 ch1 reg%0d", r), 8'(16 + r * 4), 32'd0);
        end
        step(5);
        chk_reg("t6 ch0 idle", C0_CNT, 32'd0);
        chk_irq("t6 quiet", 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
